// File: rtl/psum_xchg_hub.sv
// ============================================================================
// Module   : psum_xchg_hub
// Purpose  : N-channel partial-sum exchange hub with one FWFT FIFO per core.
//            EXCHANGE mode rotates FIFO heads to the neighbouring core.
//            REDUCE mode adds one head from every channel and broadcasts the
//            total to all cores.
// Options  : `define SUM_SAT_EN -> an overflowing reduce result saturates to
//            all ones. When undefined, the result wraps to the low SW bits.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module psum_xchg_hub #(
  parameter int NCH   = 2,
  parameter int SW    = 16,
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode,
  input  logic [NCH-1:0]    wr,
  input  logic [NCH*SW-1:0] sum_in,
  input  logic [NCH-1:0]    rd,
  output logic [NCH*SW-1:0] sum_out,
  output logic [NCH-1:0]    sum_valid,
  output logic [NCH-1:0]    full,
  output logic [NCH-1:0]    empty,
  output logic              err,
  output logic              ovf
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int SUMW = SW + $clog2(NCH);

  typedef enum logic [1:0] {
    ST_XCHG  = 2'd0,
    ST_RED   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  logic [SW-1:0]   r_red_q;
  logic            r_red_valid;
  logic            r_err;
  logic            r_ovf;

  logic [SW-1:0]   w_head [NCH];
  logic [NCH-1:0]  w_pop;
  logic            w_consume;
  logic            w_load;
  logic            w_ovf;
  logic            w_drop;
  logic [SUMW-1:0] w_sum;
  logic [SW-1:0]   w_red_res;

  assign err = r_err;
  assign ovf = r_ovf;

  // A reduce result is consumed only when every core accepts it together.
  assign w_consume = r_red_valid & (&rd);
  assign w_load    = (r_state == ST_RED) & ~(|empty) & (~r_red_valid | w_consume);
  assign w_drop    = |(wr & full & ~w_pop);

  // Unsigned sum of all heads, carried at full width to detect overflow.
  always_comb begin
    w_sum = '0;
    for (int j = 0; j < NCH; j++) begin
      w_sum = w_sum + SUMW'(w_head[j]);
    end
  end

  assign w_ovf = |w_sum[SUMW-1:SW];

`ifdef SUM_SAT_EN
  assign w_red_res = w_ovf ? {SW{1'b1}} : w_sum[SW-1:0];
`else
  assign w_red_res = w_sum[SW-1:0];
`endif

  generate
    for (genvar g = 0; g < NCH; g++) begin : g_ch
      localparam int SRC  = (g + 1) % NCH;
      localparam int PREV = (g + NCH - 1) % NCH;

      logic [SW-1:0] r_mem [DEPTH];
      logic [AW-1:0] r_wptr;
      logic [AW-1:0] r_rptr;
      logic [CW-1:0] r_cnt;
      logic          r_full_q;
      logic          r_empty_q;
      logic          w_push;
      logic [CW-1:0] w_cnt_nxt;

      assign w_head[g] = r_mem[r_rptr];
      assign full[g]   = r_full_q;
      assign empty[g]  = r_empty_q;

      // FIFO g feeds output PREV in exchange mode; all FIFOs pop together on a reduce load.
      assign w_pop[g]  = (r_state == ST_XCHG) ? (rd[PREV] & ~r_empty_q) : w_load;
      assign w_push    = wr[g] & (~r_full_q | w_pop[g]);

      assign sum_valid[g]        = (r_state == ST_XCHG) ? ~empty[SRC] : r_red_valid;
      assign sum_out[g*SW +: SW] = (r_state == ST_XCHG) ? w_head[SRC] : r_red_q;

      // Occupancy after this cycle's push/pop.
      always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_push && !w_pop[g]) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end else if (!w_push && w_pop[g]) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end

      // Storage array; contents are discarded on reset by clearing the pointers.
      always_ff @(posedge clk) begin
        if (w_push) begin
          r_mem[r_wptr] <= sum_in[g*SW +: SW];
        end
      end

      // Pointers, occupancy and registered full/empty flags.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_wptr    <= '0;
          r_rptr    <= '0;
          r_cnt     <= '0;
          r_full_q  <= 1'b0;
          r_empty_q <= 1'b1;
        end else begin
          if (w_push)   r_wptr <= r_wptr + AW'(1);
          if (w_pop[g]) r_rptr <= r_rptr + AW'(1);
          r_cnt     <= w_cnt_nxt;
          r_full_q  <= (w_cnt_nxt == CW'(DEPTH));
          r_empty_q <= (w_cnt_nxt == '0);
        end
      end
    end
  endgenerate

  // Mode FSM, reduce output register and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_XCHG;
      r_red_q     <= '0;
      r_red_valid <= 1'b0;
      r_err       <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_load) begin
        r_red_q     <= w_red_res;
        r_red_valid <= 1'b1;
        if (w_ovf) begin
          r_ovf <= 1'b1;
          r_err <= 1'b1;
        end
      end else if (w_consume) begin
        r_red_valid <= 1'b0;
      end

      if (w_drop) begin
        r_err <= 1'b1;
      end

      case (r_state)
        ST_XCHG: begin
          if (mode) r_state <= ST_RED;
        end
        ST_RED: begin
          // A load on the leaving cycle also needs draining, or its result would be stranded.
          if (!mode) r_state <= (r_red_valid || w_load) ? ST_DRAIN : ST_XCHG;
        end
        ST_DRAIN: begin
          if (!r_red_valid) r_state <= ST_XCHG;
        end
        default: r_state <= ST_XCHG;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_psum_xchg_hub.sv
// ============================================================================
// Module   : tb_psum_xchg_hub
// Purpose  : Self-checking bench for psum_xchg_hub (NCH=2, SW=16, DEPTH=16)
//            using a queue-based reference model of the hub.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_psum_xchg_hub;

  localparam int NCH   = 2;
  localparam int SW    = 16;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mode = 1'b0;
  logic [1:0]  wr = '0;
  logic [1:0]  rd = '0;
  logic [31:0] sum_in = '0;
  logic [31:0] sum_out;
  logic [1:0]  sum_valid;
  logic [1:0]  full;
  logic [1:0]  empty;
  logic        err;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per channel plus the reduce register and flags.
  logic [15:0] mq [2][$];
  int          mst;          // 0 exchange, 1 reduce, 2 draining
  logic [15:0] mred;
  logic        mrv;
  logic        merr;
  logic        movf;

  always #5 clk = ~clk;

  psum_xchg_hub #(.NCH(NCH), .SW(SW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .wr        (wr),
    .sum_in    (sum_in),
    .rd        (rd),
    .sum_out   (sum_out),
    .sum_valid (sum_valid),
    .full      (full),
    .empty     (empty),
    .err       (err),
    .ovf       (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    mq[0].delete();
    mq[1].delete();
    mst  = 0;
    mred = '0;
    mrv  = 1'b0;
    merr = 1'b0;
    movf = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_empty"}, 32'(empty), 32'h3);
    chk({tag, "_full"},  32'(full),  32'h0);
    chk({tag, "_valid"}, 32'(sum_valid), 32'h0);
    chk({tag, "_err"},   32'(err), 32'h0);
    chk({tag, "_ovf"},   32'(ovf), 32'h0);
  endtask

  // One clock: compare outputs to the model, then advance the model across the edge.
  task automatic cycle();
    logic [1:0]  ev;
    logic [15:0] eo [2];
    logic [1:0]  pop;
    logic [1:0]  push;
    logic [1:0]  eempty;
    logic [1:0]  efull;
    logic        load;
    logic        cons;
    int          s;
    int          nst;

    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (mst == 0) begin
        ev[i] = (mq[(i + 1) % 2].size() != 0);
        eo[i] = ev[i] ? mq[(i + 1) % 2][0] : 16'h0;
      end else begin
        ev[i] = mrv;
        eo[i] = mred;
      end
      eempty[i] = (mq[i].size() == 0);
      efull[i]  = (mq[i].size() == DEPTH);
    end
    chk("valid", 32'(sum_valid), 32'(ev));
    chk("empty", 32'(empty), 32'(eempty));
    chk("full",  32'(full),  32'(efull));
    chk("err",   32'(err),   32'(merr));
    chk("ovf",   32'(ovf),   32'(movf));
    for (int i = 0; i < 2; i++) begin
      if (ev[i]) chk("data", 32'(sum_out[i*16 +: 16]), 32'(eo[i]));
    end

    cons = mrv & (&rd);
    load = 1'b0;
    pop  = '0;
    if (mst == 0) begin
      for (int i = 0; i < 2; i++) begin
        if (rd[i] && ev[i]) pop[(i + 1) % 2] = 1'b1;
      end
    end else if (mst == 1) begin
      load = (mq[0].size() != 0) && (mq[1].size() != 0) && (!mrv || cons);
      if (load) pop = 2'b11;
    end
    for (int i = 0; i < 2; i++) begin
      push[i] = wr[i] && ((mq[i].size() < DEPTH) || pop[i]);
      if (wr[i] && !push[i]) merr = 1'b1;
    end

    nst = mst;
    if (mst == 0 && mode) nst = 1;
    else if (mst == 1 && !mode) nst = (mrv || load) ? 2 : 0;
    else if (mst == 2 && !mrv) nst = 0;

    if (load) begin
      s = int'(mq[0][0]) + int'(mq[1][0]);
      if (s > 65535) begin
        movf = 1'b1;
        merr = 1'b1;
`ifdef SUM_SAT_EN
        mred = 16'hFFFF;
`else
        mred = 16'(s);
`endif
      end else begin
        mred = 16'(s);
      end
      mrv = 1'b1;
    end else if (cons) begin
      mrv = 1'b0;
    end
    mst = nst;

    for (int i = 0; i < 2; i++) begin
      if (pop[i]) void'(mq[i].pop_front());
      if (push[i]) mq[i].push_back(sum_in[i*16 +: 16]);
    end

    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] exp5;

    // Power-on reset, asserted away from a clock edge.
    #2 reset = 1'b1;
    #1 chk_reset_vals("rst_init");
    @(negedge clk) reset = 1'b0;
    @(posedge clk) #1;
    mreset();
    cycle();

    // Exchange: one word per channel comes out rotated.
    wr = 2'b11; sum_in = {16'h0022, 16'h0011};
    cycle();
    wr = 2'b00;
    chk("t2_out",   sum_out, 32'h0011_0022);
    chk("t2_valid", 32'(sum_valid), 32'h3);
    rd = 2'b11;
    cycle();
    rd = 2'b00;
    chk("t2_empty", 32'(empty), 32'h3);

    // Fill channel 0, overfill once, then drain through output 1.
    for (int k = 1; k <= 16; k++) begin
      wr = 2'b01; sum_in = {16'h0, 16'(k)};
      cycle();
    end
    chk("t3_full", 32'(full[0]), 32'h1);
    sum_in = {16'h0, 16'h0011};
    cycle();
    wr = 2'b00;
    chk("t3_err", 32'(err), 32'h1);
    for (int k = 1; k <= 16; k++) begin
      chk("t3_drain", 32'(sum_out[31:16]), 32'(k));
      rd = 2'b10;
      cycle();
    end
    rd = 2'b00;
    chk("t3_empty", 32'(empty), 32'h3);

    // Reset asserted mid-burst takes effect without a clock edge.
    wr = 2'b11; sum_in = {16'h0abc, 16'h0def};
    cycle();
    cycle();
    #1 reset = 1'b1;
    #1 chk_reset_vals("rst_mid");
    wr = 2'b00;
    mreset();
    @(negedge clk) reset = 1'b0;
    @(posedge clk) #1;
    cycle();

    // Reduce: heads arrive three cycles apart.
    mode = 1'b1;
    cycle();
    wr = 2'b01; sum_in = {16'h0, 16'h1000};
    cycle();
    wr = 2'b00;
    cycle();
    cycle();
    wr = 2'b10; sum_in = {16'h2345, 16'h0};
    cycle();
    wr = 2'b00;
    cycle();
    chk("t4_out",   sum_out, 32'h3345_3345);
    chk("t4_valid", 32'(sum_valid), 32'h3);
    rd = 2'b01;
    cycle();
    chk("t4_hold", sum_out, 32'h3345_3345);
    rd = 2'b11;
    cycle();
    rd = 2'b00;
    chk("t4_cons", 32'(sum_valid), 32'h0);

    // Reduce overflow.
`ifdef SUM_SAT_EN
    exp5 = 16'hFFFF;
`else
    exp5 = 16'h0010;
`endif
    wr = 2'b11; sum_in = {16'h0020, 16'hFFF0};
    cycle();
    wr = 2'b00;
    cycle();
    chk("t5_out", 32'(sum_out[15:0]), 32'(exp5));
    chk("t5_ovf", 32'(ovf), 32'h1);
    chk("t5_err", 32'(err), 32'h1);
    rd = 2'b11;
    cycle();
    rd = 2'b00;

    // Leave reduce with a result pending: drain, then rotate queued words.
    wr = 2'b11; sum_in = {16'h0007, 16'h0005};
    cycle();
    wr = 2'b00;
    cycle();
    mode = 1'b0;
    wr = 2'b11; sum_in = {16'h0bbb, 16'h0aaa};
    cycle();
    wr = 2'b00;
    cycle();
    cycle();
    chk("t6_hold",  sum_out, 32'h000C_000C);
    chk("t6_nopop", 32'(empty), 32'h0);
    rd = 2'b11;
    cycle();
    rd = 2'b00;
    cycle();
    chk("t6_rot",   sum_out, 32'h0aaa_0bbb);
    chk("t6_valid", 32'(sum_valid), 32'h3);

    // Randomised traffic with occasional mode flips.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      wr     = 2'($urandom);
      rd     = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'($urandom);
      sum_in = $urandom;
      cycle();
    end
    wr = 2'b00;
    rd = 2'b00;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
